// File: rtl/dsp_mac_simd.sv
// dsp_mac_simd: LANES-wide signed multiply-accumulate, 3-stage pipeline, frame counting,
// pattern detect and sticky overflow flags. Define DSP_MAC_SAT_EN to saturate P on overflow.
module dsp_mac_simd #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int LANES     = 2,
  parameter int ACC_WIDTH = 48,
  parameter int ACC_LEN   = 16,
  parameter logic [ACC_WIDTH-1:0] PATTERN = '0,
  parameter logic [ACC_WIDTH-1:0] MASK    = '0
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         CE,
  input  logic                         in_valid,
  input  logic [LANES*A_WIDTH-1:0]     A,
  input  logic [LANES*B_WIDTH-1:0]     B,
  input  logic                         SUB,
  input  logic                         CLR,
  output logic                         out_valid,
  output logic [LANES*ACC_WIDTH-1:0]   P,
  output logic [LANES-1:0]             PATTERNDETECT,
  output logic [LANES-1:0]             PATTERNBDETECT,
  output logic [LANES-1:0]             OVERFLOW,
  output logic [LANES-1:0]             UNDERFLOW,
  output logic [((ACC_LEN == 0) ? 1 : $clog2(ACC_LEN + 1))-1:0] frame_cnt
);
  localparam int CNT_W   = (ACC_LEN == 0) ? 1 : $clog2(ACC_LEN + 1);
  localparam int M_WIDTH = A_WIDTH + B_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(ACC_LEN);

  logic             s1_valid_q, s1_sub_q, s1_clr_q;
  logic             s2_valid_q, s2_sub_q, s2_clr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q;
  logic             first_s3, done_s3;

  // A completed frame leaves cnt_q at zero, so zero count also covers "previous sample ended a frame".
  always_comb begin
    first_s3 = (cnt_q == '0) || s2_clr_q;
    if (first_s3)
      cnt_d = CNT_W'(1);
    else if (cnt_q == CNT_MAX)
      cnt_d = CNT_MAX;
    else
      cnt_d = cnt_q + CNT_W'(1);
    done_s3 = (ACC_LEN == 0) || (cnt_d == CNT_LEN);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_clr_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sub_q    <= 1'b0;
      s2_clr_q    <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (CE) begin
      s1_valid_q  <= in_valid;
      s1_sub_q    <= SUB;
      s1_clr_q    <= CLR;
      s2_valid_q  <= s1_valid_q;
      s2_sub_q    <= s1_sub_q;
      s2_clr_q    <= s1_clr_q;
      out_valid_q <= s2_valid_q && done_s3;
      if (s2_valid_q)
        cnt_q <= (done_s3 && ACC_LEN != 0) ? '0 : cnt_d;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign frame_cnt = cnt_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [A_WIDTH-1:0] a_q;
    logic signed [B_WIDTH-1:0] b_q;
    logic signed [M_WIDTH-1:0] m_q;
    logic [ACC_WIDTH-1:0]      p_q, p_d;
    logic [ACC_WIDTH:0]        base, addend, sum;
    logic                      ovf_d, unf_d;
    logic                      ovf_q, unf_q, pd_q, pbd_q;

    // One guard bit: guard and MSB disagreeing means the signed result left the ACC_WIDTH range.
    always_comb begin
      base   = first_s3 ? '0 : {p_q[ACC_WIDTH-1], p_q};
      addend = {{(ACC_WIDTH + 1 - M_WIDTH){m_q[M_WIDTH-1]}}, m_q};
      sum    = s2_sub_q ? (base - addend) : (base + addend);
      ovf_d  = ~sum[ACC_WIDTH] &  sum[ACC_WIDTH-1];
      unf_d  =  sum[ACC_WIDTH] & ~sum[ACC_WIDTH-1];
`ifdef DSP_MAC_SAT_EN
      if (ovf_d)
        p_d = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      else if (unf_d)
        p_d = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else
        p_d = sum[ACC_WIDTH-1:0];
`else
      p_d = sum[ACC_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
      if (RST) begin
        a_q   <= '0;
        b_q   <= '0;
        m_q   <= '0;
        p_q   <= '0;
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
        pd_q  <= &(~PATTERN | MASK);
        pbd_q <= &(PATTERN | MASK);
      end else if (CE) begin
        a_q <= A[gi*A_WIDTH +: A_WIDTH];
        b_q <= B[gi*B_WIDTH +: B_WIDTH];
        m_q <= M_WIDTH'(a_q) * M_WIDTH'(b_q);
        if (s2_valid_q) begin
          p_q   <= p_d;
          ovf_q <= ovf_d | (ovf_q & ~first_s3);
          unf_q <= unf_d | (unf_q & ~first_s3);
          pd_q  <= &(~(p_d ^ PATTERN) | MASK);
          pbd_q <= &((p_d ^ PATTERN) | MASK);
        end
      end
    end

    assign P[gi*ACC_WIDTH +: ACC_WIDTH] = p_q;
    assign PATTERNDETECT[gi]  = pd_q;
    assign PATTERNBDETECT[gi] = pbd_q;
    assign OVERFLOW[gi]       = ovf_q;
    assign UNDERFLOW[gi]      = unf_q;
  end

endmodule
